// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared constants and state encoding for the SCCB master
package sccb_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        TXBYTE,
        TXACK,
        STOP,
        GAP,
        RSTART,
        RXBYTE,
        MNACK,
        DONE
    } sccbState_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic [7:0] OV7670_ADDR = 8'h42;

endpackage

// File: rtl/sccb_tick_gen.sv
// rtl/sccb_tick_gen.sv - free-running quarter-SCL-period tick divider
module sccb_tick_gen #(
    parameter int TICK_DIV = 625
) (
    input  logic iCLK,
    input  logic iRST_N,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt <= '0;
        end else if (cnt == CW'(TICK_DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CW'(TICK_DIV - 1));

endmodule

// File: rtl/sccb_master_engine.sv
// rtl/sccb_master_engine.sv - bit-level SCCB master: 3-phase write, 2-phase read
module sccb_master_engine
    import sccb_pkg::*;
#(
    parameter int CLK_Freq = 25_000000,
    parameter int I2C_Freq = 10_000,
    parameter int TICK_DIV = CLK_Freq / (4 * I2C_Freq)
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        GO,
    input  logic        WR,
    input  logic [23:0] WDATA,
    output logic        END,
    output logic        ACK,
    output logic [7:0]  RDATA,
    output logic        I2C_SCLK,
    inout  wire         I2C_SDAT
);

    logic tick;

    sccb_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .tick   (tick)
    );

    sccbState_t  state, stateNxt;
    logic [1:0]  q, qNxt;
    logic [2:0]  bitCnt, bitCntNxt;
    logic [1:0]  byteIdx, byteIdxNxt;
    logic        isRead, isReadNxt;
    logic        readPart2, readPart2Nxt;
    logic [23:0] dataReg, dataRegNxt;
    logic [7:0]  rxShift, rxShiftNxt;
    logic        sclR, sclNxt;
    logic        sdaLow, sdaLowNxt;
    logic        endR, endNxt;
    logic        ackR, ackNxt;
    logic [7:0]  rdataR, rdataNxt;
    logic        rearm, rearmNxt;
    logic [1:0]  sdaSync;
    logic        sdaIn;
    logic [7:0]  curByte;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sdaSync <= 2'b11;
        end else begin
            sdaSync <= {sdaSync[0], I2C_SDAT};
        end
    end
    assign sdaIn = sdaSync[1];

    // Byte 2 is the write data on a write, the read-form address on a read
    always_comb begin
        case (byteIdx)
            2'd0:    curByte = isRead ? {dataReg[23:17], RW_WRITE} : dataReg[23:16];
            2'd1:    curByte = dataReg[15:8];
            default: curByte = isRead ? {dataReg[23:17], RW_READ} : dataReg[7:0];
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= IDLE;
            q         <= Q0;
            bitCnt    <= '0;
            byteIdx   <= '0;
            isRead    <= 1'b0;
            readPart2 <= 1'b0;
            dataReg   <= '0;
            rxShift   <= '0;
            sclR      <= 1'b1;
            sdaLow    <= 1'b0;
            endR      <= 1'b1;
            ackR      <= 1'b0;
            rdataR    <= '0;
            rearm     <= 1'b1;
        end else begin
            state     <= stateNxt;
            q         <= qNxt;
            bitCnt    <= bitCntNxt;
            byteIdx   <= byteIdxNxt;
            isRead    <= isReadNxt;
            readPart2 <= readPart2Nxt;
            dataReg   <= dataRegNxt;
            rxShift   <= rxShiftNxt;
            sclR      <= sclNxt;
            sdaLow    <= sdaLowNxt;
            endR      <= endNxt;
            ackR      <= ackNxt;
            rdataR    <= rdataNxt;
            rearm     <= rearmNxt;
        end
    end

    always_comb begin
        stateNxt     = state;
        qNxt         = q;
        bitCntNxt    = bitCnt;
        byteIdxNxt   = byteIdx;
        isReadNxt    = isRead;
        readPart2Nxt = readPart2;
        dataRegNxt   = dataReg;
        rxShiftNxt   = rxShift;
        sclNxt       = sclR;
        sdaLowNxt    = sdaLow;
        endNxt       = endR;
        ackNxt       = ackR;
        rdataNxt     = rdataR;
        rearmNxt     = rearm;

        if (!GO && endR) begin
            rearmNxt = 1'b1;
        end

        if (tick) begin
            qNxt = q + 2'd1;
            case (state)
                IDLE: begin
                    qNxt      = Q0;
                    sclNxt    = 1'b1;
                    sdaLowNxt = 1'b0;
                    // The accept tick doubles as START's idle q0 quarter
                    if (GO && rearm) begin
                        dataRegNxt   = WDATA;
                        isReadNxt    = ~WR;
                        readPart2Nxt = 1'b0;
                        byteIdxNxt   = 2'd0;
                        bitCntNxt    = 3'd0;
                        endNxt       = 1'b0;
                        ackNxt       = 1'b0;
                        rearmNxt     = 1'b0;
                        stateNxt     = START;
                        qNxt         = Q1;
                    end
                end
                START, RSTART: begin
                    sclNxt    = (q != Q3);
                    sdaLowNxt = (q != Q0);
                    if (q == Q3) begin
                        stateNxt  = TXBYTE;
                        bitCntNxt = 3'd0;
                    end
                end
                TXBYTE, TXACK, RXBYTE, MNACK: begin
                    sclNxt = (q == Q1) || (q == Q2);
                    if (q == Q0) begin
                        sdaLowNxt = (state == TXBYTE) ? ~curByte[3'd7 - bitCnt] : 1'b0;
                    end
                    if (q == Q2) begin
                        if (state == TXACK) ackNxt = ackR | sdaIn;
                        if (state == RXBYTE) rxShiftNxt = {rxShift[6:0], sdaIn};
                    end
                    if (q == Q3) begin
                        bitCntNxt = bitCnt + 3'd1;
                        case (state)
                            TXBYTE:  if (bitCnt == 3'd7) stateNxt = TXACK;
                            RXBYTE:  if (bitCnt == 3'd7) stateNxt = MNACK;
                            MNACK:   stateNxt = STOP;
                            default: begin
                                bitCntNxt = 3'd0;
                                if (isRead && byteIdx == 2'd2) begin
                                    stateNxt = RXBYTE;
                                end else if ((isRead && byteIdx == 2'd1) || byteIdx == 2'd2) begin
                                    stateNxt = STOP;
                                end else begin
                                    stateNxt   = TXBYTE;
                                    byteIdxNxt = byteIdx + 2'd1;
                                end
                            end
                        endcase
                    end
                end
                STOP: begin
                    sclNxt    = (q != Q0);
                    sdaLowNxt = (q == Q0) || (q == Q1);
                    if (q == Q3) begin
                        if (isRead && !readPart2) begin
                            stateNxt     = GAP;
                            readPart2Nxt = 1'b1;
                        end else begin
                            stateNxt = DONE;
                        end
                    end
                end
                GAP: begin
                    sclNxt    = 1'b1;
                    sdaLowNxt = 1'b0;
                    if (q == Q3) begin
                        stateNxt   = RSTART;
                        byteIdxNxt = 2'd2;
                    end
                end
                DONE: begin
                    endNxt   = 1'b1;
                    qNxt     = Q0;
                    stateNxt = IDLE;
                    if (isRead) rdataNxt = rxShift;
                end
                default: begin
                    stateNxt  = IDLE;
                    qNxt      = Q0;
                    sclNxt    = 1'b1;
                    sdaLowNxt = 1'b0;
                end
            endcase
        end
    end

    assign END      = endR;
    assign ACK      = ackR;
    assign RDATA    = rdataR;
    assign I2C_SCLK = sclR;
    assign I2C_SDAT = sdaLow ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_sccb_master_engine.sv
// tb/tb_sccb_master_engine.sv - self-checking bench for sccb_master_engine
module tb_sccb_master_engine;
    import sccb_pkg::*;

    localparam int TDIV     = 5;
    localparam int WR_TICKS = 116;
    localparam int TOK_S    = 256;
    localparam int TOK_P    = 512;
    localparam int TOK_MA   = 768;

    logic        clk   = 1'b0;
    logic        rstN  = 1'b0;
    logic        go    = 1'b0;
    logic        wr    = 1'b0;
    logic [23:0] wdata = '0;
    logic        endS;
    logic        ackS;
    logic [7:0]  rdata;
    logic        scl;
    wire         sda;

    logic        slvDrive = 1'b0;
    pullup (sda);
    assign sda = slvDrive ? 1'b0 : 1'bz;

    sccb_master_engine #(.CLK_Freq(40), .I2C_Freq(2)) dut (
        .iCLK     (clk),
        .iRST_N   (rstN),
        .GO       (go),
        .WR       (wr),
        .WDATA    (wdata),
        .END      (endS),
        .ACK      (ackS),
        .RDATA    (rdata),
        .I2C_SCLK (scl),
        .I2C_SDAT (sda)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Slave model: logs START/STOP/bytes/master-ack, acks per mask, returns rdByte on reads
    int          busLog[$];
    int          expLog[$];
    int          edges = 0;
    logic [3:0]  slot = '0;
    logic [2:0]  byteNum = '0;
    logic [7:0]  shiftIn = '0;
    logic        slaveTx = 1'b0;
    logic        nextTx = 1'b0;
    logic [7:0]  nackMask = '0;
    logic [7:0]  rdByte = '0;

    always @(scl) edges++;
    always @(sda) edges++;

    always @(negedge sda) if (scl === 1'b1) begin
        busLog.push_back(TOK_S);
        slot = '0; byteNum = '0; slaveTx = 1'b0; nextTx = 1'b0; slvDrive = 1'b0;
    end

    always @(posedge sda) if (scl === 1'b1) begin
        busLog.push_back(TOK_P);
        slaveTx = 1'b0; nextTx = 1'b0; slvDrive = 1'b0;
    end

    always @(posedge scl) begin
        if (slot < 4'd8 && !slaveTx) shiftIn = {shiftIn[6:0], sda};
        if (slot == 4'd8 && slaveTx) busLog.push_back(TOK_MA + ((sda === 1'b1) ? 1 : 0));
        slot = slot + 4'd1;
    end

    always @(negedge scl) begin
        if (slot == 4'd8) begin
            if (slaveTx) begin
                slvDrive = 1'b0;
            end else begin
                busLog.push_back(int'(shiftIn));
                slvDrive = ~nackMask[byteNum];
                if (byteNum == 3'd0 && shiftIn[0] && !nackMask[0]) nextTx = 1'b1;
            end
        end else if (slot == 4'd9) begin
            slot = '0;
            byteNum = byteNum + 3'd1;
            slvDrive = 1'b0;
            if (nextTx) begin
                slaveTx = 1'b1; nextTx = 1'b0; slvDrive = ~rdByte[7];
            end
        end else if (slaveTx && slot >= 4'd1 && slot <= 4'd7) begin
            slvDrive = ~rdByte[3'd7 - slot[2:0]];
        end
    end

    task automatic buildExp(input logic wrF, input logic [23:0] w);
        expLog.delete();
        expLog.push_back(TOK_S);
        if (wrF) begin
            expLog.push_back(int'(w[23:16]));
            expLog.push_back(int'(w[15:8]));
            expLog.push_back(int'(w[7:0]));
            expLog.push_back(TOK_P);
        end else begin
            expLog.push_back(int'({w[23:17], 1'b0}));
            expLog.push_back(int'(w[15:8]));
            expLog.push_back(TOK_P);
            expLog.push_back(TOK_S);
            expLog.push_back(int'({w[23:17], 1'b1}));
            expLog.push_back(TOK_MA + 1);
            expLog.push_back(TOK_P);
        end
    endtask

    task automatic checkLog(input string name);
        logic same;
        same = (busLog.size() == expLog.size());
        if (same) foreach (expLog[i]) if (busLog[i] != expLog[i]) same = 1'b0;
        checks++;
        if (!same) begin
            errors++;
            $display("FAIL %s bus log size=%0d required size=%0d first=%0h required first=%0h",
                     name, busLog.size(), expLog.size(),
                     (busLog.size() > 0) ? busLog[0] : -1, expLog[0]);
        end
    endtask

    task automatic waitEnd(input logic lvl, input int budget, output int cyc);
        cyc = 0;
        while (endS !== lvl && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Issues one transaction, scrambles GO/WR/WDATA while busy, returns END-low cycles
    task automatic runTxn(input string tag, input logic wrF, input logic [23:0] w, output int lowCyc);
        int n;
        go = 1'b0;
        @(negedge clk);
        busLog.delete();
        wr = wrF; wdata = w; go = 1'b1;
        waitEnd(1'b0, 4 * TDIV, n);
        check({tag, " start"}, endS, 1'b0);
        go = 1'b0; wr = ~wrF; wdata = 24'hFF_FF_FF;
        waitEnd(1'b1, 400 * TDIV, lowCyc);
        check({tag, " done"}, endS, 1'b1);
    endtask

    typedef struct {
        logic        wr;
        logic [23:0] wdata;
        logic [7:0]  nack;
        logic [7:0]  rdByte;
        logic        expAck;
        logic [7:0]  expRdata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n;

        vecs[0] = '{1'b1, {OV7670_ADDR, 16'h12_80}, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[1] = '{1'b1, {OV7670_ADDR, 16'h12_80}, 8'h02, 8'h00, 1'b1, 8'h00};
        vecs[2] = '{1'b0, {OV7670_ADDR, 16'h0A_00}, 8'h00, 8'h76, 1'b0, 8'h76};
        vecs[3] = '{1'b1, {OV7670_ADDR, 16'h3A_04}, 8'h04, 8'h00, 1'b1, 8'h76};
        vecs[4] = '{1'b0, {OV7670_ADDR, 16'h1C_FF}, 8'h00, 8'hA5, 1'b0, 8'hA5};
        vecs[5] = '{1'b0, {OV7670_ADDR, 16'h0B_00}, 8'h02, 8'h3C, 1'b1, 8'h3C};

        repeat (3) @(negedge clk);
        check("reset END", endS, 1'b1);
        check("reset SCL", scl, 1'b1);
        rstN = 1'b1;
        @(negedge clk);
        edges = 0;
        repeat (10 * TDIV) @(negedge clk);
        check("idle END", endS, 1'b1);
        check("idle ACK", ackS, 1'b0);
        check("idle RDATA", rdata, 8'h00);
        check("idle SCL", scl, 1'b1);
        check("idle SDA", sda, 1'b1);
        check("idle edges", edges, 0);

        for (int i = 0; i < 6; i++) begin
            nackMask = vecs[i].nack;
            rdByte   = vecs[i].rdByte;
            buildExp(vecs[i].wr, vecs[i].wdata);
            runTxn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].wdata, cyc);
            checkLog($sformatf("vec%0d", i));
            check($sformatf("vec%0d ACK", i), ackS, vecs[i].expAck);
            check($sformatf("vec%0d RDATA", i), rdata, vecs[i].expRdata);
            check($sformatf("vec%0d SDA idle", i), sda, 1'b1);
            if (vecs[i].wr) check($sformatf("vec%0d END low cycles", i), cyc, WR_TICKS * TDIV);
        end

        // GO held high across completion must not retrigger
        nackMask = 8'h00;
        go = 1'b0;
        @(negedge clk);
        wr = 1'b1; wdata = 24'h42_12_80; go = 1'b1;
        waitEnd(1'b0, 4 * TDIV, n);
        waitEnd(1'b1, 400 * TDIV, n);
        check("held first done", endS, 1'b1);
        busLog.delete();
        edges = 0;
        repeat (20 * TDIV) @(negedge clk);
        check("held no restart END", endS, 1'b1);
        check("held no bus edges", edges, 0);
        go = 1'b0;
        @(negedge clk);
        go = 1'b1;
        buildExp(1'b1, 24'h42_12_80);
        waitEnd(1'b0, 4 * TDIV, n);
        check("rearm start", endS, 1'b0);
        waitEnd(1'b1, 400 * TDIV, cyc);
        check("rearm END low cycles", cyc, WR_TICKS * TDIV);
        repeat (20 * TDIV) @(negedge clk);
        check("rearm single END", endS, 1'b1);
        checkLog("rearm single txn");
        go = 1'b0;

        // Reset during the 4th bit (q0, SCL low) of the first byte
        @(negedge clk);
        wr = 1'b1; wdata = 24'h42_12_80; go = 1'b1;
        waitEnd(1'b0, 4 * TDIV, n);
        go = 1'b0;
        repeat (16 * TDIV + 2) @(negedge clk);
        check("abort pre SCL", scl, 1'b0);
        rstN = 1'b0;
        #1;
        check("abort SCL", scl, 1'b1);
        check("abort SDA", sda, 1'b1);
        check("abort END", endS, 1'b1);
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        check("post abort ACK", ackS, 1'b0);
        check("post abort RDATA", rdata, 8'h00);
        buildExp(1'b1, 24'h42_12_80);
        runTxn("post abort", 1'b1, 24'h42_12_80, cyc);
        checkLog("post abort");
        check("post abort END low cycles", cyc, WR_TICKS * TDIV);
        check("post abort ACK final", ackS, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
